// File: rtl/wb_pkg.sv
// wb_pkg: shared defaults, address-width derivation and write-entry type for the writeback path
package wb_pkg;
    localparam int WIDTH_DEF      = 32;
    localparam int TOTAL_REGS_DEF = 32;

    // Address width for a register bank of the given size (at least one bit).
    function automatic int aw_of(input int regs);
        return (regs > 1) ? $clog2(regs) : 1;
    endfunction

    localparam int AW_DEF = aw_of(TOTAL_REGS_DEF);

    typedef struct packed {
        logic [AW_DEF-1:0]    addr;
        logic [WIDTH_DEF-1:0] data;
    } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: circular entry storage with wrapping pointers and occupancy count; pops whenever non-empty
module wb_fifo
    import wb_pkg::*;
#(
    parameter int  EW    = AW_DEF + WIDTH_DEF,
    parameter int  DEPTH = 4,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [EW-1:0]            din_i,
    output logic                     ready_o,
    output logic                     pop_o,
    output logic [EW-1:0]            head_o,
    output logic [DEPTH-1:0][EW-1:0] mem_o,
    output logic [PW-1:0]            rptr_o,
    output logic [CW-1:0]            count_o
);
    logic [DEPTH-1:0][EW-1:0] mem_q;
    logic [PW-1:0]            rptr_q, rptr_d, wptr_q, wptr_d;
    logic [CW-1:0]            count_q, count_d;
    logic                     push;

    assign ready_o = count_q < CW'(DEPTH);
    assign pop_o   = count_q != '0;
    assign push    = push_i && ready_o;
    assign head_o  = mem_q[rptr_q];
    assign mem_o   = mem_q;
    assign rptr_o  = rptr_q;
    assign count_o = count_q;

    // Next pointers and occupancy; a simultaneous push and pop leaves the count unchanged.
    always_comb begin
        rptr_d  = pop_o ? rptr_q + PW'(1) : rptr_q;
        wptr_d  = push ? wptr_q + PW'(1) : wptr_q;
        count_d = count_q + CW'(push) - CW'(pop_o);
    end

    // Pointer and count registers, cleared asynchronously so pending entries are discarded.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rptr_q  <= '0;
            wptr_q  <= '0;
            count_q <= '0;
        end else begin
            rptr_q  <= rptr_d;
            wptr_q  <= wptr_d;
            count_q <= count_d;
        end
    end

    // Entry storage; contents are only meaningful inside the valid window.
    always_ff @(posedge clk_i) begin
        if (push) mem_q[wptr_q] <= din_i;
    end
endmodule

// File: rtl/writeback_queue.sv
// writeback_queue: buffers write results, feeds reg_bank port 3 and forwards pending values to decode
module writeback_queue
    import wb_pkg::*;
#(
    parameter int  WIDTH      = WIDTH_DEF,
    parameter int  TOTAL_REGS = TOTAL_REGS_DEF,
    parameter int  DEPTH      = 4,
    localparam int AW         = aw_of(TOTAL_REGS),
    localparam int EW         = AW + WIDTH,
    localparam int PW         = $clog2(DEPTH),
    localparam int CW         = PW + 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [AW-1:0]    IN_ADDR,
    input  logic [WIDTH-1:0] IN_DATA,
    output logic             WE3,
    output logic [AW-1:0]    RA3,
    output logic [WIDTH-1:0] WD3,
    input  logic [AW-1:0]    LK_ADDR,
    output logic             LK_HIT,
    output logic [WIDTH-1:0] LK_DATA,
    output logic             EMPTY
);
    logic                     pop;
    logic [EW-1:0]            head;
    logic [DEPTH-1:0][EW-1:0] mem;
    logic [PW-1:0]            rptr, idx;
    logic [CW-1:0]            count;
    logic                     we3_q;
    logic [AW-1:0]            ra3_q;
    logic [WIDTH-1:0]         wd3_q;

    wb_fifo #(.EW(EW), .DEPTH(DEPTH)) u_fifo (
        .clk_i   (CLK),
        .rst_i   (RST),
        .push_i  (IN_VALID),
        .din_i   ({IN_ADDR, IN_DATA}),
        .ready_o (IN_READY),
        .pop_o   (pop),
        .head_o  (head),
        .mem_o   (mem),
        .rptr_o  (rptr),
        .count_o (count)
    );

    assign WE3   = we3_q;
    assign RA3   = ra3_q;
    assign WD3   = wd3_q;
    assign EMPTY = (count == '0) && !we3_q;

    // Output stage: present the oldest entry to the register bank for exactly one cycle.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            we3_q <= 1'b0;
            ra3_q <= '0;
            wd3_q <= '0;
        end else begin
            we3_q <= pop;
            if (pop) {ra3_q, wd3_q} <= head;
        end
    end

    // Forwarding lookup: output stage is oldest, queue scanned oldest to youngest so the youngest match wins.
    always_comb begin
        LK_HIT  = we3_q && (ra3_q == LK_ADDR);
        LK_DATA = LK_HIT ? wd3_q : '0;
        idx     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rptr + PW'(i);
            if (CW'(i) < count && mem[idx][EW-1:WIDTH] == LK_ADDR) begin
                LK_HIT  = 1'b1;
                LK_DATA = mem[idx][WIDTH-1:0];
            end
        end
    end
endmodule
